// File: rtl/visualizer_pkg.sv
// Shared constants and types for the spectrum bar visualizer.
// Bar geometry is fixed by the 480-line display split into 10-line blocks.
package visualizer_pkg;
  localparam int NUM_BARS   = 20;
  localparam int HEIGHT_W   = 6;
  localparam int MAX_HEIGHT = 48;
  localparam int IDX_W      = 5;

  typedef logic [HEIGHT_W-1:0] height_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } sched_state_t;
endpackage

// File: rtl/magnitude_scaler.sv
// Combinational magnitude-to-height conversion: right shift, then clamp to
// the tallest bar the screen can show.
module magnitude_scaler
  import visualizer_pkg::*;
#(
  parameter int MAG_W     = 16,
  parameter int MAG_SHIFT = 10
) (
  input  logic [MAG_W-1:0]    mag,
  output logic [HEIGHT_W-1:0] scaled
);
  logic [MAG_W-1:0] shifted;

  always_comb begin
    shifted = mag >> MAG_SHIFT;
    if (shifted > MAG_W'(MAX_HEIGHT)) begin
      scaled = HEIGHT_W'(MAX_HEIGHT);
    end else begin
      scaled = shifted[HEIGHT_W-1:0];
    end
  end
endmodule

// File: rtl/bar_height_scheduler.sv
// Captures per-bin peak magnitudes between frames and commits them, one bar
// per clock, into the registered heights driving the bar renderer.
module bar_height_scheduler
  import visualizer_pkg::*;
#(
  parameter int MAG_W      = 16,
  parameter int MAG_SHIFT  = 10,
  parameter int DECAY_STEP = 1,
  parameter int DECAY_DIV  = 2
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         frame_tick,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IDX_W-1:0]             in_bin,
  input  logic [MAG_W-1:0]             in_mag,
  input  logic                         clr_overrun,
  output logic [NUM_BARS*HEIGHT_W-1:0] height,
  output logic                         busy,
  output logic                         commit_done,
  output logic                         overrun,
  output logic                         dbg_state,
  output logic [IDX_W-1:0]             dbg_idx
);
  // Handshake: a sample transfers on a rising CLK edge where in_valid && in_ready;
  // in_ready is high only in IDLE and does not depend on in_valid.
  localparam int FC_W = $clog2(DECAY_DIV + 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(DECAY_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BARS - 1);
  localparam height_t          DSTEP    = HEIGHT_W'(DECAY_STEP);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             decay_en_q, decay_en_d;
  logic             overrun_q, overrun_d;
  logic             last_bar, done_arm_q, commit_done_q;
  logic             accept;
  height_t          scaled, cur_h, dec_h, new_h;
  height_t          shadow_q [NUM_BARS];
  height_t          height_q [NUM_BARS];

  magnitude_scaler #(.MAG_W(MAG_W), .MAG_SHIFT(MAG_SHIFT)) u_scaler (
    .mag    (in_mag),
    .scaled (scaled)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      decay_en_q    <= 1'b0;
      overrun_q     <= 1'b0;
      done_arm_q    <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      decay_en_q    <= decay_en_d;
      overrun_q     <= overrun_d;
      done_arm_q    <= last_bar;
      commit_done_q <= done_arm_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    decay_en_d  = decay_en_q;
    overrun_d   = overrun_q;
    last_bar    = 1'b0;
    in_ready    = (state_q == IDLE);
    busy        = (state_q == COMMIT);
    if (clr_overrun) overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d     = COMMIT;
          idx_d       = '0;
          decay_en_d  = (frame_cnt_q == FC_LAST);
          frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + FC_W'(1);
        end
      end
      COMMIT: begin
        // A late tick is dropped; only the sticky flag records it.
        if (frame_tick) overrun_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d  = IDLE;
          idx_d    = '0;
          last_bar = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    cur_h = height_q[idx_q];
    if (decay_en_q) begin
      dec_h = (cur_h > DSTEP) ? cur_h - DSTEP : '0;
    end else begin
      dec_h = cur_h;
    end
    new_h = (shadow_q[idx_q] > dec_h) ? shadow_q[idx_q] : dec_h;
  end

  // Accept and commit are mutually exclusive because they key off disjoint states.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        shadow_q[i] <= '0;
        height_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BARS; i++) begin
        if (state_q == COMMIT && idx_q == IDX_W'(i)) begin
          height_q[i] <= new_h;
          shadow_q[i] <= '0;
        end else if (accept && in_bin == IDX_W'(i) && scaled > shadow_q[i]) begin
          shadow_q[i] <= scaled;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BARS; g++) begin : g_height
    assign height[g*HEIGHT_W +: HEIGHT_W] = height_q[g];
  end

  assign commit_done = commit_done_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;
  assign dbg_idx     = idx_q;
endmodule

// File: tb/tb_bar_height_scheduler.sv
// Directed bench for bar_height_scheduler: vector table for scaling plus
// hand-written sequences for timing, decay, overrun and handshake corners.
module tb_bar_height_scheduler;
  import visualizer_pkg::*;

  logic                         CLK;
  logic                         RESET_N;
  logic                         frame_tick;
  logic                         in_valid;
  logic                         in_ready;
  logic [4:0]                   in_bin;
  logic [15:0]                  in_mag;
  logic                         clr_overrun;
  logic [NUM_BARS*HEIGHT_W-1:0] height;
  logic                         busy;
  logic                         commit_done;
  logic                         overrun;
  logic                         dbg_state;
  logic [4:0]                   dbg_idx;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [4:0]  bin;
    logic [15:0] mag;
    logic [5:0]  exp_h;
  } vec_t;

  vec_t vecs [7];
  int   exp_h [NUM_BARS];

  bar_height_scheduler dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .frame_tick  (frame_tick),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bin      (in_bin),
    .in_mag      (in_mag),
    .clr_overrun (clr_overrun),
    .height      (height),
    .busy        (busy),
    .commit_done (commit_done),
    .overrun     (overrun),
    .dbg_state   (dbg_state),
    .dbg_idx     (dbg_idx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int get_h(int k);
    return int'(height[k*HEIGHT_W +: HEIGHT_W]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_bars(input string tag);
    for (int k = 0; k < NUM_BARS; k++) chk($sformatf("%s_h%0d", tag, k), get_h(k), exp_h[k]);
  endtask

  task automatic clear_exp();
    for (int k = 0; k < NUM_BARS; k++) exp_h[k] = 0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; frame_tick = 1'b0; in_valid = 1'b0;
    in_bin = '0; in_mag = '0; clr_overrun = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  // Called at a negedge; one sample is accepted on the following posedge.
  task automatic send(input int bin, input int mag);
    in_valid = 1'b1; in_bin = 5'(bin); in_mag = 16'(mag);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Called at a negedge. Returns edges from the tick edge to commit_done.
  task automatic run_commit(output int edges);
    int n;
    n = 0;
    frame_tick = 1'b1;
    do begin
      @(negedge CLK);
      n++;
      frame_tick = 1'b0;
    end while (!commit_done && n < 40);
    edges = n - 1;
    if (!commit_done) chk("commit_timeout", 0, 1);
  endtask

  initial begin
    int edges;
    int n;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{5'd3,  16'h5000, 6'd20};
    vecs[1] = '{5'd4,  16'hFFFF, 6'd48};
    vecs[2] = '{5'd0,  16'h03FF, 6'd0};
    vecs[3] = '{5'd1,  16'h0400, 6'd1};
    vecs[4] = '{5'd19, 16'hC000, 6'd48};
    vecs[5] = '{5'd7,  16'hBFFF, 6'd47};
    vecs[6] = '{5'd10, 16'hC400, 6'd48};

    // Reset state
    do_reset();
    clear_exp();
    check_all_bars("rst");
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_commit_done", commit_done, 0);

    // Scale / saturate table, all loaded in one frame, with commit timing
    for (int v = 0; v < 7; v++) send(vecs[v].bin, vecs[v].mag);
    frame_tick = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      frame_tick = 1'b0;
      if (n == 1)  chk("commit_busy", busy, 1);
      if (n == 10) chk("commit_in_ready_low", in_ready, 0);
      if (n == 21) chk("commit_in_ready_back", in_ready, 1);
    end while (!commit_done && n < 40);
    chk("commit_done_latency", n - 1, 21);
    @(negedge CLK);
    chk("commit_done_width", commit_done, 0);
    for (int v = 0; v < 7; v++) chk($sformatf("scale_bin%0d", vecs[v].bin), get_h(vecs[v].bin), vecs[v].exp_h);
    chk("scale_untouched", get_h(2), 0);

    // Reset in the middle of a commit
    send(0, 16'h1400);
    frame_tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      frame_tick = 1'b0;
    end
    chk("midrst_idx", dbg_idx, 7);
    RESET_N = 1'b0;
    #1;
    clear_exp();
    check_all_bars("midrst");
    chk("midrst_busy", busy, 0);
    do_reset();

    // Peak capture and shadow clear
    send(5, 16'h2800);
    send(5, 16'h7800);
    send(5, 16'h3000);
    run_commit(edges);
    chk("peak_h5", get_h(5), 30);
    run_commit(edges);
    chk("peak_shadow_cleared", get_h(5), 29);

    // Decay sequence from a fresh frame counter, including underflow floor
    do_reset();
    send(0, 16'h1400);
    send(1, 16'h0400);
    run_commit(edges);
    chk("decay_c1_b0", get_h(0), 5);
    chk("decay_c1_b1", get_h(1), 1);
    run_commit(edges);
    chk("decay_c2_b0", get_h(0), 4);
    chk("decay_c2_b1", get_h(1), 0);
    run_commit(edges);
    chk("decay_c3_b0", get_h(0), 4);
    run_commit(edges);
    chk("decay_c4_b0", get_h(0), 3);
    chk("decay_c4_b1", get_h(1), 0);

    // Overrun: second tick 5 cycles into a commit
    do_reset();
    frame_tick = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      frame_tick = (n == 5);
      if (n == 7) chk("ovr_set", overrun, 1);
    end while (!commit_done && n < 40);
    frame_tick = 1'b0;
    chk("ovr_commit_len", n - 1, 21);
    chk("ovr_no_restart", in_ready, 1);
    clr_overrun = 1'b1;
    @(negedge CLK);
    clr_overrun = 1'b0;
    chk("ovr_cleared", overrun, 0);
    frame_tick = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
    repeat (3) @(negedge CLK);
    frame_tick = 1'b1; clr_overrun = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0; clr_overrun = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    n = 0;
    while (!commit_done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("ovr_second_done", commit_done, 1);

    // Handshake: same-edge sample included, samples blocked while busy
    do_reset();
    in_valid = 1'b1; in_bin = 5'd19; in_mag = 16'h2800;
    frame_tick = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      frame_tick = 1'b0;
      in_bin = 5'd8; in_mag = 16'hFFFF;
      if (n == 20) in_valid = 1'b0;
      if (n == 3) chk("hs_ready_low", in_ready, 0);
    end while (!commit_done && n < 40);
    in_valid = 1'b0;
    chk("hs_same_edge_h19", get_h(19), 10);
    chk("hs_busy_h8", get_h(8), 0);
    run_commit(edges);
    chk("hs_no_busy_accept_h8", get_h(8), 0);
    chk("hs_decay_h19", get_h(19), 9);
    send(25, 16'hFFFF);
    run_commit(edges);
    clear_exp();
    exp_h[19] = 9;
    check_all_bars("bin25");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
